// File: rtl/jtag_multichain_tap.sv
// IEEE 1149.1 TAP controller with BYPASS, optional IDCODE (macro JTAG_IDCODE_EN) and NUM_CHAINS selectable external scan chains.
// Latency: tdi->tdo is 1 tck through BYPASS, 0 added through a chain; tdo/tdo_oe register on negedge tck.
// Backpressure: none, every transfer is paced by tck/tms from the JTAG host.
module jtag_multichain_tap #(
    parameter int          IR_W       = 4,
    parameter int          NUM_CHAINS = 2,
    parameter int          CHAIN_BASE = 3,
    parameter logic [31:0] IDCODE     = 32'h0000_0001
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_oe,
    output logic [NUM_CHAINS-1:0] chain_sel,
    output logic                  chain_si,
    input  logic [NUM_CHAINS-1:0] chain_so,
    output logic                  shift_dr,
    output logic                  capture_dr,
    output logic                  update_dr,
    output logic [IR_W-1:0]       ir_q
);

    if (IR_W < 2 || NUM_CHAINS < 1) begin : g_bad_size
        $error("jtag_multichain_tap: IR_W must be >= 2 and NUM_CHAINS >= 1");
    end
    if (CHAIN_BASE + NUM_CHAINS - 1 >= (1 << IR_W) - 1) begin : g_bad_opcode
        $error("jtag_multichain_tap: chain opcodes collide with BYPASS or exceed IR width");
    end
    if (IDCODE[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_multichain_tap: IDCODE bit0 must be 1");
    end

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = IR_W'(1);
`else
    localparam logic [IR_W-1:0] IR_RST = '1;
`endif

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR_S, EXIT1_DR, PAUSE_DR, EXIT2_DR,
        UPD_DR, SEL_IR, CAP_IR, SHIFT_IR_S, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    tap_state_t      state, state_nxt;
    logic [IR_W-1:0] ir_sr;
    logic            bypass_q;
    logic            dr_src;

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) state <= TLR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:        state_nxt = tms ? TLR      : RTI;
            RTI:        state_nxt = tms ? SEL_DR   : RTI;
            SEL_DR:     state_nxt = tms ? SEL_IR   : CAP_DR;
            CAP_DR:     state_nxt = tms ? EXIT1_DR : SHIFT_DR_S;
            SHIFT_DR_S: state_nxt = tms ? EXIT1_DR : SHIFT_DR_S;
            EXIT1_DR:   state_nxt = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR:   state_nxt = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:   state_nxt = tms ? UPD_DR   : SHIFT_DR_S;
            UPD_DR:     state_nxt = tms ? SEL_DR   : RTI;
            SEL_IR:     state_nxt = tms ? TLR      : CAP_IR;
            CAP_IR:     state_nxt = tms ? EXIT1_IR : SHIFT_IR_S;
            SHIFT_IR_S: state_nxt = tms ? EXIT1_IR : SHIFT_IR_S;
            EXIT1_IR:   state_nxt = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR:   state_nxt = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:   state_nxt = tms ? UPD_IR   : SHIFT_IR_S;
            UPD_IR:     state_nxt = tms ? SEL_DR   : RTI;
            default:    state_nxt = TLR;
        endcase
    end

    // Reset instruction is loaded on the edge that enters TLR, so tms-reset matches trst.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_sr <= '0;
            ir_q  <= IR_RST;
        end else begin
            if (state == CAP_IR)
                ir_sr <= IR_W'(1);
            else if (state == SHIFT_IR_S)
                ir_sr <= {tdi, ir_sr[IR_W-1:1]};
            if (state_nxt == TLR)
                ir_q <= IR_RST;
            else if (state == UPD_IR)
                ir_q <= ir_sr;
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst)                    bypass_q <= 1'b0;
        else if (state == CAP_DR)     bypass_q <= 1'b0;
        else if (state == SHIFT_DR_S) bypass_q <= tdi;
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_q;
    logic        sel_idcode;

    assign sel_idcode = (ir_q == IR_W'(1));

    always_ff @(posedge tck or negedge trst) begin
        if (!trst)                    idcode_q <= IDCODE;
        else if (state == CAP_DR)     idcode_q <= IDCODE;
        else if (state == SHIFT_DR_S) idcode_q <= {tdi, idcode_q[31:1]};
    end
`endif

    always_comb begin
        chain_sel = '0;
        for (int k = 0; k < NUM_CHAINS; k++)
            if (ir_q == IR_W'(CHAIN_BASE + k)) chain_sel[k] = 1'b1;
`ifdef JTAG_IDCODE_EN
        if (sel_idcode) chain_sel = '0;
`endif
    end

    always_comb begin
        dr_src = bypass_q;
        for (int k = 0; k < NUM_CHAINS; k++)
            if (chain_sel[k]) dr_src = chain_so[k];
`ifdef JTAG_IDCODE_EN
        if (sel_idcode) dr_src = idcode_q[0];
`endif
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else begin
            tdo_oe <= (state == SHIFT_IR_S) || (state == SHIFT_DR_S);
            if (state == SHIFT_IR_S)
                tdo <= ir_sr[0];
            else if (state == SHIFT_DR_S)
                tdo <= dr_src;
        end
    end

    assign chain_si   = tdi;
    assign shift_dr   = (state == SHIFT_DR_S) && (|chain_sel);
    assign capture_dr = (state == CAP_DR)     && (|chain_sel);
    assign update_dr  = (state == UPD_DR)     && (|chain_sel);

endmodule

// File: tb/tb_jtag_multichain_tap.sv
// Directed bench for jtag_multichain_tap: IR/DR scans, BYPASS, IDCODE, two modelled external chains.
module tb_jtag_multichain_tap;

    localparam int IR_W = 4;
    localparam int NC   = 2;
    localparam int LEN1 = 502;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] IR_RST = 4'b0001;
`else
    localparam logic [3:0] IR_RST = 4'b1111;
`endif

    logic            tck = 1'b0;
    logic            trst, tms, tdi;
    logic            tdo, tdo_oe, chain_si, shift_dr, capture_dr, update_dr;
    logic [NC-1:0]   chain_sel, chain_so;
    logic [IR_W-1:0] ir_q;

    jtag_multichain_tap #(
        .IR_W(IR_W), .NUM_CHAINS(NC), .CHAIN_BASE(3), .IDCODE(32'hDEAD_BEEF)
    ) dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
        .chain_sel(chain_sel), .chain_si(chain_si), .chain_so(chain_so),
        .shift_dr(shift_dr), .capture_dr(capture_dr), .update_dr(update_dr), .ir_q(ir_q)
    );

    always #5 tck = ~tck;

    // External scan chains: chain 0 is 8 cells, chain 1 is 502 cells.
    logic [7:0]      c0 = '0;
    logic [LEN1-1:0] c1 = '0;
    int c0_shifts = 0, c1_shifts = 0, cap_cnt = 0, upd_cnt = 0;

    always @(posedge tck) begin
        if (shift_dr && chain_sel[0]) begin
            c0 <= {c0[6:0], chain_si};
            c0_shifts <= c0_shifts + 1;
        end
        if (shift_dr && chain_sel[1]) begin
            c1 <= {c1[LEN1-2:0], chain_si};
            c1_shifts <= c1_shifts + 1;
        end
        if (capture_dr) cap_cnt <= cap_cnt + 1;
        if (update_dr)  upd_cnt <= upd_cnt + 1;
    end
    assign chain_so = {c1[LEN1-1], c0[7]};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic din  [0:1023];
    logic dout [0:1023];

    // One tck: drive inputs, read tdo as the host would just before the rising edge.
    task automatic step(input logic t_ms, input logic t_di, output logic t_do);
        tms  = t_ms;
        tdi  = t_di;
        t_do = tdo;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic shift_ir(input logic [IR_W-1:0] val, output logic [IR_W-1:0] cap);
        logic d;
        step(1, 0, d); step(1, 0, d); step(0, 0, d); step(0, 0, d);
        for (int i = 0; i < IR_W; i++) step(i == IR_W - 1, val[i], cap[i]);
        step(1, 0, d); step(0, 0, d);
    endtask

    task automatic shift_dr_scan(input int n);
        logic d;
        step(1, 0, d); step(0, 0, d); step(0, 0, d);
        for (int i = 0; i < n; i++) step(i == n - 1, din[i], dout[i]);
        step(1, 0, d); step(0, 0, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]     v32, d32;
        logic [3:0]      cap, v4;
        logic            d;
        int              errs;

        trst = 1'b0; tms = 1'b1; tdi = 1'b0;
        repeat (2) @(negedge tck);
        #1;
        check("rst_tdo", 32'(tdo), 0);
        check("rst_tdo_oe", 32'(tdo_oe), 0);
        check("rst_chain_sel", 32'(chain_sel), 0);
        check("rst_shift_dr", 32'(shift_dr), 0);
        check("rst_capture_dr", 32'(capture_dr), 0);
        check("rst_update_dr", 32'(update_dr), 0);
        check("rst_ir_q", 32'(ir_q), 32'(IR_RST));
        trst = 1'b1;
        step(0, 0, d);

        // Reset instruction selects IDCODE (macro) or BYPASS.
        d32 = 32'h1234_5678;
`ifdef JTAG_IDCODE_EN
        d32 = 32'h0;
`endif
        for (int i = 0; i < 32; i++) din[i] = d32[i];
        shift_dr_scan(32);
        for (int i = 0; i < 32; i++) v32[i] = dout[i];
`ifdef JTAG_IDCODE_EN
        check("idcode_read", v32, 32'hDEAD_BEEF);
`else
        check("reset_bypass_read", v32, 32'h2468_ACF0);
`endif

        // Explicit BYPASS: tdi 1,0,1,1 -> tdo 0,1,0,1.
        shift_ir(4'b1111, cap);
        check("ir_capture_a", 32'(cap), 32'h1);
        check("bypass_ir_q", 32'(ir_q), 32'hF);
        check("bypass_chain_sel", 32'(chain_sel), 0);
        din[0] = 1; din[1] = 0; din[2] = 1; din[3] = 1;
        shift_dr_scan(4);
        for (int i = 0; i < 4; i++) v4[i] = dout[i];
        check("bypass_1011", 32'(v4), 32'b1010);

        // Unmapped opcode behaves as BYPASS.
        shift_ir(4'b1001, cap);
        check("ir_capture_b", 32'(cap), 32'h1);
        check("unmapped_ir_q", 32'(ir_q), 32'h9);
        check("unmapped_chain_sel", 32'(chain_sel), 0);
        din[0] = 1; din[1] = 1; din[2] = 0; din[3] = 1;
        shift_dr_scan(4);
        for (int i = 0; i < 4; i++) v4[i] = dout[i];
        check("unmapped_bypass", 32'(v4), 32'b0110);
        check("unmapped_no_capture", 32'(cap_cnt), 0);

        // Chain 1: push a 502-bit pattern then 502 zeros; pattern reappears on tdo.
        shift_ir(4'b0100, cap);
        check("chain1_sel", 32'(chain_sel), 32'b10);
        for (int i = 0; i < LEN1; i++) begin
            din[i]        = ((i * 37 + i / 5) % 3) == 0;
            din[LEN1 + i] = 1'b0;
        end
        shift_dr_scan(2 * LEN1);
        errs = 0;
        for (int i = 0; i < LEN1; i++) if (dout[LEN1 + i] !== din[i]) errs++;
        check("chain1_pattern_errs", 32'(errs), 0);
        check("chain1_shift_count", 32'(c1_shifts), 32'(2 * LEN1));
        check("chain0_untouched", 32'(c0_shifts), 0);
        check("chain1_capture_count", 32'(cap_cnt), 1);
        check("chain1_update_count", 32'(upd_cnt), 1);

        // tms=1 for 5 edges from the middle of Shift-DR lands in TLR.
        step(1, 0, d); step(0, 0, d); step(0, 0, d);
        for (int i = 0; i < 3; i++) step(0, 1, d);
        check("mid_scan_shift_dr", 32'(shift_dr), 1);
        for (int i = 0; i < 5; i++) step(1, 0, d);
        check("tms_reset_ir_q", 32'(ir_q), 32'(IR_RST));
        check("tms_reset_chain_sel", 32'(chain_sel), 0);
        check("tms_reset_tdo_oe", 32'(tdo_oe), 0);
        step(0, 0, d);

        // Chain 0 scan interrupted by trst.
        shift_ir(4'b0011, cap);
        check("ir_capture_after_tlr", 32'(cap), 32'h1);
        check("chain0_sel", 32'(chain_sel), 32'b01);
        step(1, 0, d); step(0, 0, d); step(0, 0, d);
        for (int i = 0; i < 10; i++) step(0, 1, d);
        check("pre_trst_shift_dr", 32'(shift_dr), 1);
        check("pre_trst_tdo_oe", 32'(tdo_oe), 1);
        check("pre_trst_tdo", 32'(tdo), 1);
        trst = 1'b0;
        #1;
        check("trst_chain_sel", 32'(chain_sel), 0);
        check("trst_shift_dr", 32'(shift_dr), 0);
        check("trst_tdo_oe", 32'(tdo_oe), 0);
        check("trst_tdo", 32'(tdo), 0);
        check("trst_ir_q", 32'(ir_q), 32'(IR_RST));
        #20;
        trst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
